control_sequencer: RTL and testbench

Hardwired multi-cycle control unit for the 32-bit CPU datapath. It generates, cycle by cycle, the register-transfer control signals that the datapath benches drive by hand: fetch (T0–T2), operand moves into Y, the ALU operation, and write-back to the general registers or to HI/LO. It sits beside `datapath`, reads the datapath's IR output, and drives the datapath's strobe, select and opcode inputs directly.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/control_sequencer_if.sv | 24 ++
 rtl/reg_select_decode.sv | 10 +
 rtl/control_sequencer.sv | 76 +++++++
 tb/tb_control_sequencer.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: sequencer states, opcodes, IR field layout and opcode classification helpers
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_SHL = 5'b01000;
   localparam logic [4:0] OP_MUL = 5'b01111;
   localparam logic [4:0] OP_DIV = 5'b10000;

   localparam int OP_LSB = 27;
   localparam int RA_LSB = 23;
   localparam int RB_LSB = 19;
   localparam int RC_LSB = 15;

   function automatic logic [4:0] ir_op(input logic [31:0] ir);
      return ir[OP_LSB +: 5];
   endfunction

   function automatic logic [3:0] ir_ra(input logic [31:0] ir);
      return ir[RA_LSB +: 4];
   endfunction

   function automatic logic [3:0] ir_rb(input logic [31:0] ir);
      return ir[RB_LSB +: 4];
   endfunction

   function automatic logic [3:0] ir_rc(input logic [31:0] ir);
      return ir[RC_LSB +: 4];
   endfunction

   function automatic logic is_3reg_op(input logic [4:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL};
   endfunction

   function automatic logic is_hilo_op(input logic [4:0] op);
      return op inside {OP_MUL, OP_DIV};
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath control bundle between the sequencer and the datapath
interface control_sequencer_if #(parameter int NREGS = 16);

   logic [31:0]      IR;
   logic [NREGS-1:0] Rin;
   logic [NREGS-1:0] Rout;
   logic             PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
   logic             PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
   logic             IncPC, Read;
   logic [4:0]       alu_op;

   modport master (
      input  IR,
      output Rin, Rout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
      output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, alu_op
   );

   modport slave (
      output IR,
      input  Rin, Rout, PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
      input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, alu_op
   );

endinterface

// File: rtl/reg_select_decode.sv
// reg_select_decode: 4-bit register field to one-hot select, all-zero when disabled
module reg_select_decode #(parameter int NREGS = 16) (
   input  logic [3:0]       sel,
   input  logic             en,
   output logic [NREGS-1:0] onehot
);

   assign onehot = en ? NREGS'(1) << sel : '0;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit driving the datapath strobes
module control_sequencer import cpu_ctrl_pkg::*; #(parameter int NREGS = 16) (
   input  logic                Clock,
   input  logic                clear,
   input  logic                Stop,
   output logic                Run,
   output logic                Illegal,
   control_sequencer_if.master bus
);

   state_t     state;
   logic [4:0] op;
   logic       three, hilo, legal;
   logic       rout_en, rin_en;
   logic [3:0] rout_sel;
   logic       unused_ir;

   assign op        = ir_op(bus.IR);
   assign three     = is_3reg_op(op);
   assign hilo      = is_hilo_op(op);
   assign legal     = three | hilo;
   assign unused_ir = ^bus.IR[RC_LSB-1:0];

   // State advance; instruction end honours Stop, reset beats everything and clears Illegal
   always_ff @(posedge Clock) begin
      if (!clear) begin
         state   <= S_RST;
         Illegal <= 1'b0;
      end else begin
         case (state)
            S_RST:   state <= S_T0;
            S_T0:    state <= S_T1;
            S_T1:    state <= S_T2;
            S_T2:    state <= S_T3;
            S_T3: begin
               state   <= legal ? S_T4 : S_HALT;
               Illegal <= Illegal | ~legal;
            end
            S_T4:    state <= S_T5;
            S_T5:    state <= hilo ? S_T6 : (Stop ? S_HALT : S_T0);
            S_T6:    state <= Stop ? S_HALT : S_T0;
            S_HALT:  state <= S_HALT;
            default: state <= S_RST;
         endcase
      end
   end

   assign Run = state != S_RST && state != S_HALT;

   assign rout_en  = (state == S_T3 && legal) || state == S_T4;
   assign rout_sel = state == S_T3 ? (three ? ir_rb(bus.IR) : ir_ra(bus.IR))
                                   : (three ? ir_rc(bus.IR) : ir_rb(bus.IR));
   assign rin_en   = state == S_T5 && three;

   reg_select_decode #(.NREGS(NREGS)) u_rout (.sel(rout_sel),       .en(rout_en), .onehot(bus.Rout));
   reg_select_decode #(.NREGS(NREGS)) u_rin  (.sel(ir_ra(bus.IR)),  .en(rin_en),  .onehot(bus.Rin));

   assign bus.PCout    = state == S_T0;
   assign bus.MARin    = state == S_T0;
   assign bus.IncPC    = state == S_T0;
   assign bus.Zin      = state == S_T0 || state == S_T4;
   assign bus.Zlowout  = state == S_T1 || state == S_T5;
   assign bus.PCin     = state == S_T1;
   assign bus.Read     = state == S_T1;
   assign bus.MDRin    = state == S_T1;
   assign bus.MDRout   = state == S_T2;
   assign bus.IRin     = state == S_T2;
   assign bus.Yin      = state == S_T3 && legal;
   assign bus.LOin     = state == S_T5 && hilo;
   assign bus.Zhighout = state == S_T6;
   assign bus.HIin     = state == S_T6;
   assign bus.HIout    = 1'b0;
   assign bus.LOout    = 1'b0;
   assign bus.alu_op   = state == S_T4 ? op : 5'b00000;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed cycle-by-cycle check of the control sequencer outputs
module tb_control_sequencer;

   // ctl order: PCout Zhighout Zlowout MDRout HIout LOout | PCin MARin MDRin IRin | Yin Zin HIin LOin | IncPC Read Run Illegal
   localparam logic [17:0] C_ZERO = 18'b000000_0000_0000_0000;
   localparam logic [17:0] C_T0   = 18'b100000_0100_0100_1010;
   localparam logic [17:0] C_T1   = 18'b001000_1010_0000_0110;
   localparam logic [17:0] C_T2   = 18'b000100_0001_0000_0010;
   localparam logic [17:0] C_T3   = 18'b000000_0000_1000_0010;
   localparam logic [17:0] C_T3I  = 18'b000000_0000_0000_0010;
   localparam logic [17:0] C_T4   = 18'b000000_0000_0100_0010;
   localparam logic [17:0] C_T5R  = 18'b001000_0000_0000_0010;
   localparam logic [17:0] C_T5H  = 18'b001000_0000_0001_0010;
   localparam logic [17:0] C_T6   = 18'b010000_0000_0010_0010;
   localparam logic [17:0] C_HI   = 18'b000000_0000_0000_0001;

   localparam logic [31:0] I_ADD = 32'h19918000;
   localparam logic [31:0] I_AND = 32'h28918000;
   localparam logic [31:0] I_DIV = 32'h83380000;
   localparam logic [31:0] I_MUL = 32'h7B380000;
   localparam logic [31:0] I_ILL = 32'hF8000000;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic        Stop  = 1'b0;
   logic        Run, Illegal;
   logic [17:0] ctl;
   int          checks = 0;
   int          errors = 0;

   control_sequencer_if #(.NREGS(16)) bus();

   control_sequencer #(.NREGS(16)) dut (
      .Clock(Clock), .clear(clear), .Stop(Stop), .Run(Run), .Illegal(Illegal), .bus(bus)
   );

   always #5 Clock = ~Clock;

   assign ctl = {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.HIout, bus.LOout,
                 bus.PCin, bus.MARin, bus.MDRin, bus.IRin,
                 bus.Yin, bus.Zin, bus.HIin, bus.LOin,
                 bus.IncPC, bus.Read, Run, Illegal};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare the current cycle (sampled at negedge), then move on to the next negedge
   task automatic cyc(input string tag, input logic [17:0] c, input logic [15:0] rin,
                      input logic [15:0] rout, input logic [4:0] alu);
      check({tag, ".ctl"},  32'(ctl),        32'(c));
      check({tag, ".rin"},  32'(bus.Rin),    32'(rin));
      check({tag, ".rout"}, 32'(bus.Rout),   32'(rout));
      check({tag, ".alu"},  32'(bus.alu_op), 32'(alu));
      @(negedge Clock);
   endtask

   initial begin
      bus.IR = 32'h0;
      @(negedge Clock);
      @(negedge Clock);
      clear = 1'b1;
      cyc("rst", C_ZERO, 16'h0, 16'h0, 5'b0);
      bus.IR = I_ADD;
      cyc("add_t0", C_T0,  16'h0, 16'h0,    5'b0);
      cyc("add_t1", C_T1,  16'h0, 16'h0,    5'b0);
      cyc("add_t2", C_T2,  16'h0, 16'h0,    5'b0);
      cyc("add_t3", C_T3,  16'h0, 16'h0004, 5'b0);
      cyc("add_t4", C_T4,  16'h0, 16'h0008, 5'b00011);
      cyc("add_t5", C_T5R, 16'h0008, 16'h0, 5'b0);
      bus.IR = I_AND;
      cyc("and_t0", C_T0,  16'h0, 16'h0,    5'b0);
      Stop = 1'b1;
      cyc("and_t1", C_T1,  16'h0, 16'h0,    5'b0);
      Stop = 1'b0;
      cyc("and_t2", C_T2,  16'h0, 16'h0,    5'b0);
      cyc("and_t3", C_T3,  16'h0, 16'h0004, 5'b0);
      cyc("and_t4", C_T4,  16'h0, 16'h0008, 5'b00101);
      cyc("and_t5", C_T5R, 16'h0002, 16'h0, 5'b0);
      bus.IR = I_DIV;
      cyc("div_t0", C_T0,  16'h0, 16'h0,    5'b0);
      cyc("div_t1", C_T1,  16'h0, 16'h0,    5'b0);
      cyc("div_t2", C_T2,  16'h0, 16'h0,    5'b0);
      cyc("div_t3", C_T3,  16'h0, 16'h0040, 5'b0);
      cyc("div_t4", C_T4,  16'h0, 16'h0080, 5'b10000);
      cyc("div_t5", C_T5H, 16'h0, 16'h0,    5'b0);
      cyc("div_t6", C_T6,  16'h0, 16'h0,    5'b0);
      bus.IR = I_ADD;
      cyc("st_t0", C_T0,  16'h0, 16'h0,    5'b0);
      cyc("st_t1", C_T1,  16'h0, 16'h0,    5'b0);
      Stop = 1'b1;
      cyc("st_t2", C_T2,  16'h0, 16'h0,    5'b0);
      cyc("st_t3", C_T3,  16'h0, 16'h0004, 5'b0);
      cyc("st_t4", C_T4,  16'h0, 16'h0008, 5'b00011);
      cyc("st_t5", C_T5R, 16'h0008, 16'h0, 5'b0);
      cyc("st_halt",  C_ZERO, 16'h0, 16'h0, 5'b0);
      cyc("st_halt2", C_ZERO, 16'h0, 16'h0, 5'b0);
      clear = 1'b0;
      cyc("st_halt3", C_ZERO, 16'h0, 16'h0, 5'b0);
      clear = 1'b1;
      cyc("st_rst", C_ZERO, 16'h0, 16'h0, 5'b0);
      cyc("st_rst_t0", C_T0, 16'h0, 16'h0, 5'b0);
      Stop = 1'b0;
      bus.IR = I_MUL;
      cyc("mul_t1", C_T1, 16'h0, 16'h0,    5'b0);
      cyc("mul_t2", C_T2, 16'h0, 16'h0,    5'b0);
      cyc("mul_t3", C_T3, 16'h0, 16'h0040, 5'b0);
      clear = 1'b0;
      cyc("mul_t4", C_T4, 16'h0, 16'h0080, 5'b01111);
      clear = 1'b1;
      cyc("mul_rst",    C_ZERO, 16'h0, 16'h0, 5'b0);
      cyc("mul_rst_t0", C_T0,   16'h0, 16'h0, 5'b0);
      bus.IR = I_ILL;
      cyc("ill_t1", C_T1,  16'h0, 16'h0, 5'b0);
      cyc("ill_t2", C_T2,  16'h0, 16'h0, 5'b0);
      cyc("ill_t3", C_T3I, 16'h0, 16'h0, 5'b0);
      cyc("ill_halt",  C_HI, 16'h0, 16'h0, 5'b0);
      cyc("ill_halt2", C_HI, 16'h0, 16'h0, 5'b0);
      clear = 1'b0;
      cyc("ill_halt3", C_HI, 16'h0, 16'h0, 5'b0);
      clear = 1'b1;
      cyc("ill_rst", C_ZERO, 16'h0, 16'h0, 5'b0);
      bus.IR = I_ADD;
      cyc("sim_t0", C_T0, 16'h0, 16'h0,    5'b0);
      cyc("sim_t1", C_T1, 16'h0, 16'h0,    5'b0);
      cyc("sim_t2", C_T2, 16'h0, 16'h0,    5'b0);
      cyc("sim_t3", C_T3, 16'h0, 16'h0004, 5'b0);
      cyc("sim_t4", C_T4, 16'h0, 16'h0008, 5'b00011);
      Stop  = 1'b1;
      clear = 1'b0;
      cyc("sim_t5", C_T5R, 16'h0008, 16'h0, 5'b0);
      clear = 1'b1;
      cyc("sim_rst", C_ZERO, 16'h0, 16'h0, 5'b0);
      Stop = 1'b0;
      cyc("sim_rst_t0", C_T0, 16'h0, 16'h0, 5'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
